// File: rtl/tile_router_v1_00_a_output_arbiter_if.sv
// Handshake bundle between the input-port clients, the output arbiter and the output link.
interface tile_router_v1_00_a_output_arbiter_if #(
  parameter int C_NUM_REQUESTERS = 8,
  parameter int C_PACKET_WIDTH   = 66
);
  logic [C_NUM_REQUESTERS-1:0]                reqX_valid;
  logic [C_NUM_REQUESTERS-1:0]                reqX_accept;
  logic [C_NUM_REQUESTERS*C_PACKET_WIDTH-1:0] reqX_payload;
  logic                                       output_valid;
  logic                                       output_accept;
  logic [C_PACKET_WIDTH-1:0]                  output_payload;

  // master: requesters plus downstream link; slave: the arbiter
  modport master (
    output reqX_valid, reqX_payload, output_accept,
    input  reqX_accept, output_valid, output_payload
  );
  modport slave (
    input  reqX_valid, reqX_payload, output_accept,
    output reqX_accept, output_valid, output_payload
  );
endinterface

// File: rtl/tile_router_v1_00_a_output_arbiter.sv
// Round-robin output-port arbiter with a single registered output slot (valid/accept).
// Optional statistics counters are enabled by defining TILE_ROUTER_ARB_STATS_EN.
`ifdef TILE_ROUTER_ARB_STATS_EN
module tile_router_v1_00_a_output_arbiter_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 32'd1;
  end
endmodule
`endif

module tile_router_v1_00_a_output_arbiter #(
  parameter int C_NUM_REQUESTERS = 8,
  parameter int C_PACKET_WIDTH   = 66,
  parameter int C_PORT_TYPE      = 0
) (
  input  logic clk,
  input  logic rst,
  tile_router_v1_00_a_output_arbiter_if.slave bus
`ifdef TILE_ROUTER_ARB_STATS_EN
  ,
  output logic [32*C_NUM_REQUESTERS-1:0] grant_count,
  output logic [31:0]                    stall_count
`endif
);
  localparam int N     = C_NUM_REQUESTERS;
  localparam int W     = C_PACKET_WIDTH;
  localparam int PTR_W = $clog2(N);
  localparam logic [PTR_W:0] NUM = (PTR_W+1)'(N);

  if (C_NUM_REQUESTERS < 2 || C_PORT_TYPE < 0) begin : g_cfg_chk
    $error("tile_router output arbiter: need at least 2 requesters and a non-negative port type");
  end

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic [W-1:0]       r_out_payload;
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [N-1:0][W-1:0] w_req_pl;
  logic [PTR_W:0]      w_sum;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic                w_any;
  logic                w_can_load;
  logic                w_grant;

  assign w_req_pl = bus.reqX_payload;

  // Walk from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = N-1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= NUM) w_sum = w_sum - NUM;
      if (bus.reqX_valid[w_sum[PTR_W-1:0]]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_sum[PTR_W-1:0];
      end
    end
  end

  // Accept is gated by reset so nothing is handed over while the slot is being cleared.
  assign w_can_load      = (r_state == EMPTY) | bus.output_accept;
  assign w_grant         = w_can_load & w_any & rst;
  assign bus.reqX_accept = w_grant ? (N'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= EMPTY;
      r_out_valid   <= 1'b0;
      r_out_payload <= '0;
      r_rr_ptr      <= '0;
    end else begin
      case (r_state)
        EMPTY:   if (w_grant) r_state <= FULL;
        FULL:    if (bus.output_accept && !w_grant) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
      if (w_grant) begin
        r_out_valid   <= 1'b1;
        r_out_payload <= w_req_pl[w_gnt_idx];
        r_rr_ptr      <= (w_gnt_idx == PTR_W'(N-1)) ? '0 : w_gnt_idx + 1'b1;
      end else if (bus.output_accept) begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign bus.output_valid   = r_out_valid;
  assign bus.output_payload = r_out_payload;

`ifdef TILE_ROUTER_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_gcnt
    tile_router_v1_00_a_output_arbiter_sat_cnt u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (w_grant && (w_gnt_idx == PTR_W'(i))),
      .cnt (grant_count[i*32 +: 32])
    );
  end

  tile_router_v1_00_a_output_arbiter_sat_cnt u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (r_out_valid & ~bus.output_accept),
    .cnt (stall_count)
  );
`endif

endmodule

// File: tb/tb_tile_router_v1_00_a_output_arbiter.sv
// Directed bench: stimulus pushes expected packets, a negedge monitor pops and compares.
module tb_tile_router_v1_00_a_output_arbiter;
  localparam int N = 8;
  localparam int W = 66;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_router_v1_00_a_output_arbiter_if #(.C_NUM_REQUESTERS(N), .C_PACKET_WIDTH(W)) bus ();

`ifdef TILE_ROUTER_ARB_STATS_EN
  logic [32*N-1:0] grant_count;
  logic [31:0]     stall_count;
`endif

  tile_router_v1_00_a_output_arbiter #(
    .C_NUM_REQUESTERS (N),
    .C_PACKET_WIDTH   (W),
    .C_PORT_TYPE      (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef TILE_ROUTER_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  logic [W-1:0] pl [N];
  logic [W-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every output transfer must match the oldest outstanding expected packet.
  always @(negedge clk) begin
    if (rst && bus.output_valid && bus.output_accept) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got %h expected no packet", bus.output_payload);
      end else begin
        chk("out_payload", bus.output_payload, exp_q.pop_front());
      end
    end
  end

  // One cycle: drive inputs after the edge, check the combinational accept, and
  // optionally the output slot state. exp_ov < 0 means don't care.
  task automatic step(input string nm, input logic [N-1:0] v, input logic acc,
                      input logic [N-1:0] exp_acc, input int exp_ov);
    @(posedge clk); #1;
    bus.reqX_valid    = v;
    bus.output_accept = acc;
    #1;
    chk({nm, "_acc"}, W'(bus.reqX_accept), W'(exp_acc));
    if (exp_ov >= 0) chk({nm, "_ov"}, W'(bus.output_valid), W'(exp_ov[0]));
    if (exp_ov == 1 && !acc && exp_q.size() > 0) chk({nm, "_hold"}, bus.output_payload, exp_q[0]);
    for (int i = 0; i < N; i++) if (exp_acc[i]) exp_q.push_back(pl[i]);
  endtask

  task automatic pulse_reset(input string nm, input logic [N-1:0] v_in, input logic [N-1:0] v_after,
                             input logic [N-1:0] exp_after);
    @(posedge clk); #1;
    rst               = 1'b0;
    bus.reqX_valid    = v_in;
    bus.output_accept = 1'b1;
    #1;
    chk({nm, "_rst_ov"},  W'(bus.output_valid), '0);
    chk({nm, "_rst_pl"},  bus.output_payload, '0);
    chk({nm, "_rst_acc"}, W'(bus.reqX_accept), '0);
`ifdef TILE_ROUTER_ARB_STATS_EN
    chk({nm, "_rst_stall"}, W'(stall_count), '0);
    chk({nm, "_rst_gcnt"},  W'(grant_count[0 +: 64]), '0);
`endif
    exp_q.delete();
    @(posedge clk); #1;
    bus.reqX_valid = v_after;
    rst            = 1'b1;
    #1;
    chk({nm, "_rel_acc"}, W'(bus.reqX_accept), W'(exp_after));
    for (int i = 0; i < N; i++) if (exp_after[i]) exp_q.push_back(pl[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++)
      pl[i] = {2'(i), 32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)};
    pl[2] = 66'h155;
    bus.reqX_valid    = '0;
    bus.output_accept = 1'b0;
    for (int i = 0; i < N; i++) bus.reqX_payload[i*W +: W] = pl[i];
    #1;

    // Reset: accept held low even with every requester valid
    pulse_reset("init", 8'hFF, 8'h00, 8'h00);

    // Single request from requester 2; rr_ptr then 3, so 3 beats 2
    step("t1_a", 8'h04, 1'b1, 8'h04, 0);
    step("t1_b", 8'h0C, 1'b1, 8'h08, 1);
    step("t1_c", 8'h00, 1'b1, 8'h00, 1);

    // All eight valid for 16 cycles from rr_ptr=0: strict rotation, no gaps
    pulse_reset("t2", 8'hFF, 8'h00, 8'h00);
    for (int k = 0; k < 16; k++)
      step("t2_rr", 8'hFF, 1'b1, 8'(1 << (k % 8)), (k == 0) ? 0 : 1);

    // Back-pressure: slot holds requester 7's packet for 5 cycles
    for (int k = 0; k < 5; k++) step("t3_bp", 8'h81, 1'b0, 8'h00, 1);
    step("t3_go0", 8'h81, 1'b1, 8'h01, 1);
    step("t3_go7", 8'h80, 1'b1, 8'h80, 1);
    step("t3_drn", 8'h00, 1'b1, 8'h00, 1);

    // Wrap: grant 6 sets rr_ptr=7, then 7 wins over 1, then 1
    step("t4_g6",  8'h40, 1'b1, 8'h40, 0);
    step("t4_g7",  8'h82, 1'b1, 8'h80, 1);
    step("t4_g1",  8'h02, 1'b1, 8'h02, 1);
    step("t4_drn", 8'h00, 1'b1, 8'h00, 1);

    // Reset mid-transfer: held packet dropped; rr_ptr was 4, after reset 0 wins over 4
    step("t5_g3",  8'h08, 1'b0, 8'h08, 0);
    step("t5_hld", 8'h00, 1'b0, 8'h00, 1);
    pulse_reset("t5", 8'h11, 8'h11, 8'h01);
    step("t5_g4",  8'h10, 1'b1, 8'h10, 1);
    step("t5_drn", 8'h00, 1'b1, 8'h00, 1);

    // Three grants to requester 2 with four stall cycles
    step("t6_g2a", 8'h04, 1'b1, 8'h04, 0);
    for (int k = 0; k < 4; k++) step("t6_stl", 8'h00, 1'b0, 8'h00, 1);
    step("t6_g2b", 8'h04, 1'b1, 8'h04, 1);
    step("t6_g2c", 8'h04, 1'b1, 8'h04, 1);
    step("t6_drn", 8'h00, 1'b1, 8'h00, 1);

    @(posedge clk); #1;
    chk("end_ov", W'(bus.output_valid), '0);
    chk("end_qempty", W'(exp_q.size()), '0);
`ifdef TILE_ROUTER_ARB_STATS_EN
    chk("stat_g2",    W'(grant_count[2*32 +: 32]), W'(32'd3));
    chk("stat_g0",    W'(grant_count[0*32 +: 32]), W'(32'd1));
    chk("stat_g4",    W'(grant_count[4*32 +: 32]), W'(32'd1));
    chk("stat_g7",    W'(grant_count[7*32 +: 32]), W'(32'd0));
    chk("stat_stall", W'(stall_count), W'(32'd4));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
